// File: rtl/spc_pkg.sv
// Shared constants, state encoding and signature ROM for the SPC loader.
// Offsets are file byte offsets into the SPC image held in the store.
package spc_pkg;

  localparam logic [16:0] FILE_BYTES = 17'h10180;
  localparam logic [16:0] ARAM_BASE  = 17'h00100;
  localparam logic [16:0] DSP_BASE   = 17'h10100;

  localparam int SIG_LEN = 27;
  localparam logic [16:0] OFF_SIG    = 17'h00000;
  localparam logic [16:0] OFF_PC_LO  = 17'h00025;
  localparam logic [16:0] OFF_PC_HI  = 17'h00026;
  localparam logic [16:0] OFF_A      = 17'h00027;
  localparam logic [16:0] OFF_X      = 17'h00028;
  localparam logic [16:0] OFF_Y      = 17'h00029;
  localparam logic [16:0] OFF_PSW    = 17'h0002A;
  localparam logic [16:0] OFF_SP     = 17'h0002B;

  localparam logic [6:0] DSP_KON     = 7'h4C;
  localparam logic [6:0] DSP_PRE_KON = 7'h4B;
  localparam logic [6:0] DSP_FLG     = 7'h6C;
  localparam logic [6:0] DSP_LAST    = 7'h7F;

  localparam logic [8*SIG_LEN-1:0] SIG_STR =
    "SNES-SPC700 Sound File Data";

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DSP_RD,
    ST_DSP_WR,
    ST_KON_RD,
    ST_KON_WR,
    ST_DONE,
    ST_ERR
  } state_t;

  // First character of the signature sits in the MSBs of SIG_STR.
  function automatic logic [7:0] sig_byte(input logic [4:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (idx < 5'(SIG_LEN))
      b = SIG_STR[8*(SIG_LEN-1-int'(idx)) +: 8];
    return b;
  endfunction

endpackage

// File: rtl/spc_sig_check.sv
// Header signature checker: compares the leading file bytes against
// the signature ROM and raises a sticky mismatch flag.
module spc_sig_check
  import spc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [16:0] idx,
  input  logic [7:0]  data,
  output logic        mismatch
);

  logic bad_q, bad_d;
  logic hit;

  // Flag any signature byte that differs; cleared when a load begins.
  always_comb begin
    hit = 1'b0;
    if (en && (idx < 17'(SIG_LEN)))
      hit = (data != sig_byte(idx[4:0]));
    bad_d = clr ? 1'b0 : (bad_q | hit);
  end

  // Sticky mismatch register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bad_q <= 1'b0;
    else       bad_q <= bad_d;
  end

  assign mismatch = bad_q;

endmodule

// File: rtl/spc_loader.sv
// Streams an SPC file into the ARAM/SPC store, checks its header,
// captures SMP boot registers and replays the DSP register image.
module spc_loader
  import spc_pkg::*;
#(
  parameter logic [16:0] FILE_LEN = FILE_BYTES,
  parameter logic [16:0] DSP_OFS  = DSP_BASE
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        spc_wr,
  output logic        spc_rd,
  output logic [16:0] spc_a,
  output logic [7:0]  spc_din,
  input  logic [7:0]  spc_dout,
  output logic        dsp_wr,
  output logic [6:0]  dsp_addr,
  output logic [7:0]  dsp_data,
  output logic [15:0] smp_pc,
  output logic [7:0]  smp_a,
  output logic [7:0]  smp_x,
  output logic [7:0]  smp_y,
  output logic [7:0]  smp_psw,
  output logic [7:0]  smp_sp,
  output logic        busy,
  output logic        smp_start,
  output logic        err_sig,
  output logic        err_short
);

  state_t      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic [6:0]  idx_q, idx_d;
  logic        err_short_q, err_short_d;
  logic        smp_start_q, smp_start_d;
  logic [7:0]  pc_lo_q, pc_lo_d;
  logic [7:0]  pc_hi_q, pc_hi_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  psw_q, psw_d;
  logic [7:0]  sp_q, sp_d;

  logic xfer;
  logic in_file;
  logic go;
  logic short_end;
  logic sig_bad;

  // Transfer qualifiers shared by the FSM, capture and checker.
  always_comb begin
    xfer      = (state_q == ST_LOAD) && s_valid;
    in_file   = (cnt_q < FILE_LEN);
    go        = start && ((state_q == ST_IDLE) ||
                          (state_q == ST_DONE) ||
                          (state_q == ST_ERR));
    short_end = ({1'b0, cnt_q} + 18'd1) < {1'b0, FILE_LEN};
  end

  spc_sig_check u_sig (
    .clk      (clk),
    .reset    (reset),
    .clr      (go),
    .en       (xfer),
    .idx      (cnt_q),
    .data     (s_data),
    .mismatch (sig_bad)
  );

  // Next-state and strobe generation for load and DSP replay.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    err_short_d = err_short_q;
    s_ready     = 1'b0;
    spc_wr      = 1'b0;
    spc_rd      = 1'b0;
    spc_a       = 17'h0;
    spc_din     = 8'h00;
    dsp_wr      = 1'b0;
    dsp_addr    = 7'h0;
    dsp_data    = 8'h00;
    busy        = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d     = ST_LOAD;
          cnt_d       = 17'h0;
          err_short_d = 1'b0;
        end
      end
      ST_LOAD: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (s_valid) begin
          if (in_file) begin
            spc_wr  = 1'b1;
            spc_a   = cnt_q;
            spc_din = s_data;
            cnt_d   = cnt_q + 17'd1;
          end
          if (s_last) begin
            if (short_end) begin
              err_short_d = 1'b1;
              state_d     = ST_ERR;
            end else if (sig_bad) begin
              state_d = ST_ERR;
            end else begin
              idx_d   = 7'h0;
              state_d = ST_DSP_RD;
            end
          end
        end
      end
      ST_DSP_RD: begin
        busy    = 1'b1;
        spc_rd  = 1'b1;
        spc_a   = DSP_OFS + 17'(idx_q);
        state_d = ST_DSP_WR;
      end
      ST_DSP_WR: begin
        busy     = 1'b1;
        dsp_wr   = 1'b1;
        dsp_addr = idx_q;
        dsp_data = spc_dout;
        if (idx_q == DSP_LAST) begin
          state_d = ST_KON_RD;
        end else begin
          // KON is held back so voices key on after FLG etc. are set.
          idx_d   = (idx_q == DSP_PRE_KON) ? idx_q + 7'd2
                                           : idx_q + 7'd1;
          state_d = ST_DSP_RD;
        end
      end
      ST_KON_RD: begin
        busy    = 1'b1;
        spc_rd  = 1'b1;
        spc_a   = DSP_OFS + 17'(DSP_KON);
        state_d = ST_KON_WR;
      end
      ST_KON_WR: begin
        busy     = 1'b1;
        dsp_wr   = 1'b1;
        dsp_addr = DSP_KON;
        dsp_data = spc_dout;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Boot register capture from the header as the bytes stream past.
  always_comb begin
    pc_lo_d = pc_lo_q;
    pc_hi_d = pc_hi_q;
    a_d     = a_q;
    x_d     = x_q;
    y_d     = y_q;
    psw_d   = psw_q;
    sp_d    = sp_q;
    if (xfer) begin
      unique case (cnt_q)
        OFF_PC_LO: pc_lo_d = s_data;
        OFF_PC_HI: pc_hi_d = s_data;
        OFF_A:     a_d     = s_data;
        OFF_X:     x_d     = s_data;
        OFF_Y:     y_d     = s_data;
        OFF_PSW:   psw_d   = s_data;
        OFF_SP:    sp_d    = s_data;
        default: ;
      endcase
    end
  end

  // Boot pulse fires in the first DONE cycle.
  always_comb begin
    smp_start_d = (state_q == ST_KON_WR);
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 17'h0;
      idx_q       <= 7'h0;
      err_short_q <= 1'b0;
      smp_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      err_short_q <= err_short_d;
      smp_start_q <= smp_start_d;
    end
  end

  // Captured SMP boot registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_lo_q <= 8'h00;
      pc_hi_q <= 8'h00;
      a_q     <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      psw_q   <= 8'h00;
      sp_q    <= 8'h00;
    end else begin
      pc_lo_q <= pc_lo_d;
      pc_hi_q <= pc_hi_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      psw_q   <= psw_d;
      sp_q    <= sp_d;
    end
  end

  assign smp_pc    = {pc_hi_q, pc_lo_q};
  assign smp_a     = a_q;
  assign smp_x     = x_q;
  assign smp_y     = y_q;
  assign smp_psw   = psw_q;
  assign smp_sp    = sp_q;
  assign smp_start = smp_start_q;
  assign err_sig   = sig_bad;
  assign err_short = err_short_q;

endmodule

// File: tb/tb_spc_loader.sv
// Bench for spc_loader, built with a reduced image (256 header,
// 256 ARAM, 128 DSP) so each load is a few hundred cycles.
module tb_spc_loader;

  localparam logic [16:0] FB = 17'h00280;
  localparam logic [16:0] DB = 17'h00200;
  localparam int FBI = 32'h280;
  localparam int DBI = 32'h200;

  logic        clk = 1'b0;
  logic        reset, start, s_valid, s_last;
  logic [7:0]  s_data;
  logic        s_ready, spc_wr, spc_rd, dsp_wr;
  logic [16:0] spc_a;
  logic [7:0]  spc_din, spc_dout, dsp_data;
  logic [6:0]  dsp_addr;
  logic [15:0] smp_pc;
  logic [7:0]  smp_a, smp_x, smp_y, smp_psw, smp_sp;
  logic        busy, smp_start, err_sig, err_short;

  always #5 clk = ~clk;

  spc_loader #(.FILE_LEN(FB), .DSP_OFS(DB)) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .spc_wr(spc_wr), .spc_rd(spc_rd),
    .spc_a(spc_a), .spc_din(spc_din), .spc_dout(spc_dout),
    .dsp_wr(dsp_wr), .dsp_addr(dsp_addr), .dsp_data(dsp_data),
    .smp_pc(smp_pc), .smp_a(smp_a), .smp_x(smp_x), .smp_y(smp_y),
    .smp_psw(smp_psw), .smp_sp(smp_sp), .busy(busy),
    .smp_start(smp_start), .err_sig(err_sig), .err_short(err_short)
  );

  typedef struct {
    int len; int corrupt; bit gap;
    logic [15:0] pc;
    logic [7:0] a; logic [7:0] x; logic [7:0] y;
    logic [7:0] psw; logic [7:0] sp; logic [7:0] dx;
    bit e_sig; bit e_short; bit ok;
  } vec_t;

  typedef struct { logic [16:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [6:0] a; logic [7:0] d; } dw_t;

  vec_t tv[5];
  vec_t cur;
  wr_t  wr_q[$];
  dw_t  dsp_q[$];
  wr_t  ew;
  dw_t  ed;
  logic [7:0] store [0:FBI-1];
  string sig = "SNES-SPC700 Sound File Data";

  int n_chk = 0;
  int n_fail = 0;
  int tcase = 0;
  int n_spcwr, max_a, n_dspwr, n_dspall, n_start, last_dsp;
  logic        prev_rd = 1'b0;
  logic [16:0] prev_a = 17'h0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL t%0d %s: got=%0h exp=%0h", tcase, nm, act, exp);
    end
  endtask

  function automatic logic [7:0] img(int i);
    if (i < 27) return (i == cur.corrupt) ? 8'h58 : 8'(sig[i]);
    if (i == 'h25) return cur.pc[7:0];
    if (i == 'h26) return cur.pc[15:8];
    if (i == 'h27) return cur.a;
    if (i == 'h28) return cur.x;
    if (i == 'h29) return cur.y;
    if (i == 'h2A) return cur.psw;
    if (i == 'h2B) return cur.sp;
    if (i >= DBI && i < FBI) return 8'(i - DBI) ^ cur.dx;
    return 8'(i * 7 + 3);
  endfunction

  // Store model and output scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (spc_wr | spc_rd)
      chk("wr_rd_excl", 32'(spc_wr & spc_rd), 32'd0);
    if (spc_wr) begin
      n_spcwr++;
      if (int'(spc_a) > max_a) max_a = int'(spc_a);
      if (wr_q.size() == 0) chk("spc_wr_unexp", 32'd1, 32'd0);
      else begin
        ew = wr_q.pop_front();
        chk("spc_a", 32'(spc_a), 32'(ew.a));
        chk("spc_din", 32'(spc_din), 32'(ew.d));
      end
      if (int'(spc_a) < FBI) store[spc_a] = spc_din;
    end
    if (dsp_wr) begin
      chk("rd_to_wr", {prev_rd, 14'd0, prev_a},
          {1'b1, 14'd0, DB + 17'(dsp_addr)});
      n_dspall++;
      if (dsp_addr != 7'h4C) n_dspwr++;
      last_dsp = int'(dsp_addr);
      if (dsp_q.size() == 0) chk("dsp_wr_unexp", 32'd1, 32'd0);
      else begin
        ed = dsp_q.pop_front();
        chk("dsp_addr", 32'(dsp_addr), 32'(ed.a));
        chk("dsp_data", 32'(dsp_data), 32'(ed.d));
      end
    end
    if (smp_start) n_start++;
    prev_rd = spc_rd;
    prev_a  = spc_a;
  end

  always @(posedge clk)
    if (spc_rd && int'(spc_a) < FBI) spc_dout <= store[spc_a];

  task automatic send_bytes(int from, int to, bit last, bit gap);
    for (int i = from; i < to; i++) begin
      s_data  = img(i);
      s_valid = 1'b1;
      s_last  = last && (i == to - 1);
      if (i < FBI) wr_q.push_back('{a: 17'(i), d: img(i)});
      @(negedge clk);
      if (!s_ready) begin
        chk("s_ready", 32'd0, 32'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (gap) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic prep();
    n_spcwr = 0; max_a = -1; n_dspwr = 0; n_dspall = 0;
    n_start = 0; last_dsp = -1;
    wr_q.delete();
    dsp_q.delete();
    if (cur.ok) begin
      for (int i = 0; i < 128; i++)
        if (i != 'h4C) dsp_q.push_back('{a: 7'(i), d: img(DBI + i)});
      dsp_q.push_back('{a: 7'h4C, d: img(DBI + 'h4C)});
    end
  endtask

  task automatic run_file(bit poke);
    int k;
    prep();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_bytes(0, cur.len, 1'b1, cur.gap);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    k = 0;
    do begin @(negedge clk); k++; end while (busy && k < 2000);
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic post_checks();
    int ewr;
    ewr = (cur.len < FBI) ? cur.len : FBI;
    chk("err_sig", 32'(err_sig), 32'(cur.e_sig));
    chk("err_short", 32'(err_short), 32'(cur.e_short));
    chk("busy_end", 32'(busy), 32'd0);
    chk("smp_pc", 32'(smp_pc), 32'(cur.pc));
    chk("smp_a", 32'(smp_a), 32'(cur.a));
    chk("smp_xy", {16'd0, smp_x, smp_y}, {16'd0, cur.x, cur.y});
    chk("smp_psw", 32'(smp_psw), 32'(cur.psw));
    chk("smp_sp", 32'(smp_sp), 32'(cur.sp));
    chk("smp_start_cnt", 32'(n_start), 32'(cur.ok));
    chk("spc_wr_cnt", 32'(n_spcwr), 32'(ewr));
    chk("spc_wr_max", 32'(max_a), 32'(ewr - 1));
    chk("dsp_wr_cnt", 32'(n_dspwr), cur.ok ? 32'd127 : 32'd0);
    chk("dsp_wr_all", 32'(n_dspall), cur.ok ? 32'd128 : 32'd0);
    if (cur.ok) chk("dsp_last", 32'(last_dsp), 32'h4C);
    chk("wr_q_left", 32'(wr_q.size()), 32'd0);
    chk("dsp_q_left", 32'(dsp_q.size()), 32'd0);
  endtask

  initial begin
    tv[0] = '{len: FBI, corrupt: -1, gap: 0, pc: 16'h0400,
              a: 8'h12, x: 8'h34, y: 8'h56, psw: 8'h02, sp: 8'hEF,
              dx: 8'h5A, e_sig: 0, e_short: 0, ok: 1};
    tv[1] = '{len: FBI, corrupt: 5, gap: 0, pc: 16'h1234,
              a: 8'h01, x: 8'h02, y: 8'h03, psw: 8'h04, sp: 8'h05,
              dx: 8'h11, e_sig: 1, e_short: 0, ok: 0};
    tv[2] = '{len: 'h180, corrupt: -1, gap: 0, pc: 16'hBEEF,
              a: 8'hA1, x: 8'hB2, y: 8'hC3, psw: 8'hD4, sp: 8'hE5,
              dx: 8'h22, e_sig: 0, e_short: 1, ok: 0};
    tv[3] = '{len: FBI + 64, corrupt: -1, gap: 0, pc: 16'hFFC0,
              a: 8'hFF, x: 8'h00, y: 8'h80, psw: 8'h7F, sp: 8'h01,
              dx: 8'hC3, e_sig: 0, e_short: 0, ok: 1};
    tv[4] = '{len: FBI, corrupt: -1, gap: 1, pc: 16'h0200,
              a: 8'h55, x: 8'hAA, y: 8'h33, psw: 8'hCC, sp: 8'hFE,
              dx: 8'h00, e_sig: 0, e_short: 0, ok: 1};

    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    s_data = 8'h00; spc_dout = 8'h00;
    for (int i = 0; i < FBI; i++) store[i] = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_strobes",
        {26'd0, s_ready, spc_wr, spc_rd, dsp_wr, busy, smp_start}, 32'd0);
    chk("rst_err", {30'd0, err_sig, err_short}, 32'd0);
    chk("rst_pc", 32'(smp_pc), 32'd0);
    chk("rst_regs", {smp_a, smp_x, smp_y, smp_sp}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    for (int t = 0; t < 5; t++) begin
      tcase = t;
      cur = tv[t];
      run_file(1'b0);
      post_checks();
      @(posedge clk); #1;
    end

    // Reset mid-load, then a clean reload with a stray start
    // pulse during the DSP replay.
    tcase = 5;
    cur = tv[0];
    cur.pc = 16'h0ABC;
    cur.dx = 8'h96;
    prep();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_bytes(0, 'h200, 1'b0, 1'b0);
    chk("busy_mid", 32'(busy), 32'd1);
    s_data = img('h200);
    s_valid = 1'b1;
    #1;
    chk("wr_before_rst", 32'(spc_wr), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_strobes", {29'd0, spc_wr, s_ready, busy}, 32'd0);
    chk("rst_mid_pc", 32'(smp_pc), 32'd0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    wr_q.delete();
    @(posedge clk); #1;
    run_file(1'b1);
    post_checks();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
